// File: rtl/cpu2_pkg.sv
// Shared definitions for the cpu2 ALU sequencer: ALU op codes, sequencer
// FSM states and instruction field decoding.
package cpu2_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } seq_state_e;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned REG_AW  = 2;

    // Instruction layout: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_LSB = 0;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: 2];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
        return instr[RS1_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
        return instr[RS2_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port.
module alu_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // Storage: synchronous clear on reset, single write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports see the stored value, so a write becomes visible next cycle.
    always_comb begin
        rdata_a_o  = regs_q[raddr_a_i];
        rdata_b_o  = regs_q[raddr_b_i];
        dbg_data_o = regs_q[dbg_addr_i];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences instructions onto an external combinational ALU: accepts one
// instruction per handshake, reads operands from the local register file,
// registers them onto the ALU ports, captures the result and writes it back.
module alu_sequencer
    import cpu2_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    input  logic             instr_load,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic             zero,
    output logic [7:0]       op_count,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    seq_state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic               load_q;
    logic [WIDTH-1:0]   imm_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [1:0]         alu_op_q;
    logic               done_q, zero_q;
    logic [7:0]         op_count_q;

    logic               accept;
    logic               wb_en;
    logic [WIDTH-1:0]   wb_value;
    logic [WIDTH-1:0]   rs1_data, rs2_data;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .we_i       (wb_en),
        .waddr_i    (instr_rd(instr_q)),
        .wdata_i    (wb_value),
        .raddr_a_i  (instr_rs1(instr_q)),
        .rdata_a_o  (rs1_data),
        .raddr_b_i  (instr_rs2(instr_q)),
        .rdata_b_o  (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Next-state and handshake decode; loads skip straight to write-back.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        instr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = instr_load ? S_WB : S_READ;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        wb_en    = (state_q == S_WB);
        wb_value = load_q ? imm_q : result_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Latch the offered instruction on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            load_q  <= 1'b0;
            imm_q   <= '0;
        end else if (accept) begin
            instr_q <= instr;
            load_q  <= instr_load;
            imm_q   <= imm;
        end
    end

    // ALU port registers: loaded only in READ, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else if (state_q == S_READ) begin
            alu_a_q  <= rs1_data;
            alu_b_q  <= rs2_data;
            alu_op_q <= instr_op(instr_q);
        end
    end

    // Capture the ALU output after it has had a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset)                 result_q <= '0;
        else if (state_q == S_EXEC) result_q <= alu_result;
    end

    // Completion status, updated on the write-back edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            done_q <= wb_en;
            if (wb_en) begin
                zero_q     <= (wb_value == '0);
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    // Output port drive.
    always_comb begin
        alu_a    = alu_a_q;
        alu_b    = alu_b_q;
        alu_op   = alu_op_q;
        done     = done_q;
        zero     = zero_q;
        op_count = op_count_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic       instr_load;
    logic [7:0] imm;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       done;
    logic       zero;
    logic [7:0] op_count;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .WIDTH (8),
        .NREGS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_load  (instr_load),
        .imm         (imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .zero        (zero),
        .op_count    (op_count),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            2'b11: alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Offer one instruction, wait for its handshake, return cycles to done (-1 if none).
    task automatic send(input logic [7:0] ins, input logic ld, input logic [7:0] im, output int lat);
        int g;
        @(negedge clk);
        instr = ins; instr_load = ld; imm = im; instr_valid = 1'b1;
        g = 0;
        while (instr_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; instr_valid = 1'b0; instr = 8'h00; instr_load = 1'b0;
        imm = 8'h00; dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        checks++; if ({alu_a, alu_b, alu_op} !== 18'd0) begin failures++; $display("FAIL reset_alu_ports got=%h/%h/%b exp=0", alu_a, alu_b, alu_op); end
        for (int i = 0; i < 4; i++) begin
            peek(i[1:0], d);
            checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", i, d); end
        end
    endtask

    task automatic test_load();
        int lat;
        logic [7:0] d;
        send(8'h00, 1'b1, 8'h05, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL load_r0_latency got=%0d exp=2", lat); end
        send(8'h10, 1'b1, 8'h03, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL load_r1_latency got=%0d exp=2", lat); end
        peek(2'd0, d);
        checks++; if (d !== 8'h05) begin failures++; $display("FAIL load_r0 got=%h exp=05", d); end
        peek(2'd1, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL load_r1 got=%h exp=03", d); end
        checks++; if (op_count !== 8'd2) begin failures++; $display("FAIL load_op_count got=%0d exp=2", op_count); end
    endtask

    task automatic test_add();
        int lat;
        logic [7:0] d;
        send(8'b00_10_00_01, 1'b0, 8'h00, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", lat); end
        peek(2'd2, d);
        checks++; if (d !== 8'h08) begin failures++; $display("FAIL add_r2 got=%h exp=08", d); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
        checks++; if (op_count !== 8'd3) begin failures++; $display("FAIL add_op_count got=%0d exp=3", op_count); end
        checks++; if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 2'b00}) begin
            failures++; $display("FAIL add_alu_ports_hold got=%h/%h/%b exp=05/03/00", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [7:0] d;
        send(8'b01_11_01_01, 1'b0, 8'h00, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sub_self_latency got=%0d exp=4", lat); end
        peek(2'd3, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL sub_self_r3 got=%h exp=00", d); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_self_zero got=%b exp=1", zero); end
        send(8'h00, 1'b1, 8'h03, lat);
        send(8'h10, 1'b1, 8'h05, lat);
        send(8'b01_11_00_01, 1'b0, 8'h00, lat);
        peek(2'd3, d);
        checks++; if (d !== 8'hFE) begin failures++; $display("FAIL sub_neg_r3 got=%h exp=fe", d); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL sub_neg_zero got=%b exp=0", zero); end
        checks++; if (op_count !== 8'd7) begin failures++; $display("FAIL sub_op_count got=%0d exp=7", op_count); end
    endtask

    task automatic test_back_to_back();
        // r0=3, r1=5: r2=8, r2=16, r3=r2+r0=0x13, r1=r1|r3=0x17
        logic [7:0] seq [4] = '{8'b00_10_00_01, 8'b00_10_10_10, 8'b00_11_10_00, 8'b11_01_01_11};
        int acc = 0, dones = 0, low_run = 0, bad_gaps = 0, tail = 0;
        logic [7:0] d;
        @(negedge clk);
        instr_load = 1'b0; instr = seq[0]; instr_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && tail < 8; cyc++) begin
            if (done === 1'b1) dones++;
            if (acc == 4) tail++;
            if (instr_ready === 1'b1 && instr_valid === 1'b1) begin
                if (acc > 0 && low_run != 3) bad_gaps++;
                acc++;
                low_run = 0;
                @(posedge clk);
                @(negedge clk);
                if (acc < 4) instr = seq[acc];
                else         instr_valid = 1'b0;
            end else begin
                if (instr_ready !== 1'b1) low_run++;
                @(negedge clk);
            end
        end
        checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accepted got=%0d exp=4", acc); end
        checks++; if (bad_gaps !== 0) begin failures++; $display("FAIL b2b_ready_gap got=%0d bad gaps exp=0", bad_gaps); end
        checks++; if (dones !== 4) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=4", dones); end
        checks++; if (op_count !== 8'd11) begin failures++; $display("FAIL b2b_op_count got=%0d exp=11", op_count); end
        peek(2'd1, d);
        checks++; if (d !== 8'h17) begin failures++; $display("FAIL b2b_r1 got=%h exp=17", d); end
        peek(2'd2, d);
        checks++; if (d !== 8'h10) begin failures++; $display("FAIL b2b_r2 got=%h exp=10", d); end
        peek(2'd3, d);
        checks++; if (d !== 8'h13) begin failures++; $display("FAIL b2b_r3 got=%h exp=13", d); end
    endtask

    task automatic test_dbg_during_wb();
        logic [7:0] d;
        @(negedge clk);
        instr = 8'h00; instr_load = 1'b1; imm = 8'hAA; instr_valid = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL wb_ready_idle got=%b exp=1", instr_ready); end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        peek(2'd0, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL wb_dbg_old got=%h exp=03", d); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL wb_done_early got=%b exp=0", done); end
        @(negedge clk);
        peek(2'd0, d);
        checks++; if (d !== 8'hAA) begin failures++; $display("FAIL wb_dbg_new got=%h exp=aa", d); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL wb_done got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL wb_done_pulse got=%b exp=0", done); end
        checks++; if (op_count !== 8'd12) begin failures++; $display("FAIL wb_op_count got=%0d exp=12", op_count); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        logic saw_done;
        @(negedge clk);
        instr = 8'b00_10_00_01; instr_load = 1'b0; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", instr_ready); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL abort_op_count got=%0d exp=0", op_count); end
        for (int i = 0; i < 4; i++) begin
            peek(i[1:0], d);
            checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_reg%0d got=%h exp=00", i, d); end
        end
        saw_done = done;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    endtask

    task automatic test_wrap_logic();
        int lat;
        int lat_bad = 0;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            send({2'b00, i[1:0], 4'b0000}, 1'b1, i[7:0], lat);
            if (lat != 2) lat_bad++;
            if (i == 0) begin
                checks++; if (zero !== 1'b1) begin failures++; $display("FAIL load_zero_flag got=%b exp=1", zero); end
            end
            if (i == 254) begin
                checks++; if (op_count !== 8'd255) begin failures++; $display("FAIL count_255 got=%0d exp=255", op_count); end
            end
        end
        checks++; if (lat_bad !== 0) begin failures++; $display("FAIL wrap_load_latency got=%0d bad exp=0", lat_bad); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL count_wrap got=%0d exp=0", op_count); end
        send(8'h00, 1'b1, 8'hF0, lat);
        send(8'h10, 1'b1, 8'h3C, lat);
        send(8'b10_10_00_01, 1'b0, 8'h00, lat);
        send(8'b11_11_00_01, 1'b0, 8'h00, lat);
        peek(2'd2, d);
        checks++; if (d !== 8'h30) begin failures++; $display("FAIL and_r2 got=%h exp=30", d); end
        peek(2'd3, d);
        checks++; if (d !== 8'hFC) begin failures++; $display("FAIL or_r3 got=%h exp=fc", d); end
        checks++; if (alu_op !== 2'b11) begin failures++; $display("FAIL or_alu_op got=%b exp=11", alu_op); end
        checks++; if (op_count !== 8'd4) begin failures++; $display("FAIL post_wrap_count got=%0d exp=4", op_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_sub();
        test_back_to_back();
        test_dbg_during_wb();
        test_reset_abort();
        test_wrap_logic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
